// File: rtl/lbr_ctrl.sv
// lbr_ctrl: last-branch-record sequencer: circular TOS, three file write ports,
// software reads and freeze / bulk-clear control.
module lbr_ctrl #(
   parameter  int DATA_WIDTH = 32,
   parameter  int LBR_SIZE   = 16,
   localparam int IW         = $clog2(LBR_SIZE),
   localparam int SEL_W      = IW + 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  lbr_enable,
   input  logic [3:0]            type_mask,
   input  logic                  br_valid,
   output logic                  br_ready,
   input  logic [DATA_WIDTH-1:0] br_from,
   input  logic [DATA_WIDTH-1:0] br_to,
   input  logic [1:0]            br_type,
   input  logic                  freeze_req,
   input  logic                  freeze_clr,
   input  logic                  clr_req,
   output logic                  frozen,
   output logic                  busy,
   output logic [IW-1:0]         tos,
   input  logic                  sw_rd_req,
   input  logic [SEL_W-1:0]      sw_rd_sel,
   output logic                  sw_rd_ready,
   output logic                  sw_rd_valid,
   output logic [DATA_WIDTH-1:0] sw_rd_data,
   output logic [SEL_W-1:0]      rf_read_sel,
   input  logic [DATA_WIDTH-1:0] rf_read_data,
   output logic                  rf_wEn0,
   output logic                  rf_wEn1,
   output logic                  rf_wEn2,
   output logic [SEL_W-1:0]      rf_write_sel0,
   output logic [SEL_W-1:0]      rf_write_sel1,
   output logic [SEL_W-1:0]      rf_write_sel2,
   output logic [DATA_WIDTH-1:0] rf_write_data0,
   output logic [DATA_WIDTH-1:0] rf_write_data1,
   output logic [DATA_WIDTH-1:0] rf_write_data2
);
   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] FROZEN = 2'd1;
   localparam logic [1:0] CLEAR  = 2'd2;

   logic [1:0]       state;
   logic [IW-1:0]    clr_idx;
   logic [IW-1:0]    nt;
   logic [SEL_W-1:0] sel_q;
   logic             rec;
   logic             clr_wr;
   logic             last;
   logic             rd_acc;

   assign busy        = state == CLEAR;
   assign frozen      = state == FROZEN;
   assign br_ready    = !busy;
   assign sw_rd_ready = !busy;
   assign nt          = tos + IW'(1);
   assign last        = clr_idx == IW'(LBR_SIZE - 1);
   // a clear request in the same cycle wins, so the accepted event is dropped
   assign rec    = br_valid && !busy && state == RUN && lbr_enable && type_mask[br_type] && !clr_req && !reset;
   assign clr_wr = busy && !reset;
   assign rd_acc = sw_rd_req && !busy;

   assign rf_wEn0        = rec || clr_wr;
   assign rf_wEn1        = rec || clr_wr;
   assign rf_wEn2        = rec || (clr_wr && last);
   assign rf_write_sel0  = {2'b00, busy ? clr_idx : nt};
   assign rf_write_sel1  = {2'b01, busy ? clr_idx : nt};
   assign rf_write_sel2  = {2'b10, {IW{1'b0}}};
   assign rf_write_data0 = busy ? '0 : br_from;
   assign rf_write_data1 = busy ? '0 : br_to;
   assign rf_write_data2 = busy ? DATA_WIDTH'(LBR_SIZE - 1) : DATA_WIDTH'(nt);
   assign rf_read_sel    = rd_acc ? sw_rd_sel : sel_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= RUN;
         tos         <= IW'(LBR_SIZE - 1);
         clr_idx     <= '0;
         sel_q       <= '0;
         sw_rd_valid <= 1'b0;
         sw_rd_data  <= '0;
      end else begin
         sel_q       <= rf_read_sel;
         sw_rd_valid <= rd_acc;
         if (rd_acc) sw_rd_data <= rf_read_data;
         if (rec) tos <= nt;
         if (busy) begin
            clr_idx <= clr_idx + IW'(1);
            if (last) begin
               state <= RUN;
               tos   <= IW'(LBR_SIZE - 1);
            end
         end else if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
         end else if (state == RUN && freeze_req) begin
            state <= FROZEN;
         end else if (state == FROZEN && freeze_clr) begin
            state <= RUN;
         end
      end
   end
endmodule

// File: tb/tb_lbr_ctrl.sv
// tb_lbr_ctrl: directed bench for lbr_ctrl with a behavioural register file model.
module tb_lbr_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        lbr_enable = 1'b1;
   logic [3:0]  type_mask = 4'hF;
   logic        br_valid = 1'b0;
   logic        br_ready;
   logic [31:0] br_from = '0;
   logic [31:0] br_to = '0;
   logic [1:0]  br_type = '0;
   logic        freeze_req = 1'b0;
   logic        freeze_clr = 1'b0;
   logic        clr_req = 1'b0;
   logic        frozen;
   logic        busy;
   logic [3:0]  tos;
   logic        sw_rd_req = 1'b0;
   logic [5:0]  sw_rd_sel = '0;
   logic        sw_rd_ready;
   logic        sw_rd_valid;
   logic [31:0] sw_rd_data;
   logic [5:0]  rf_read_sel;
   logic [31:0] rf_read_data;
   logic        rf_wEn0, rf_wEn1, rf_wEn2;
   logic [5:0]  rf_write_sel0, rf_write_sel1, rf_write_sel2;
   logic [31:0] rf_write_data0, rf_write_data1, rf_write_data2;
   logic [31:0] mem [64];
   int          checks = 0;
   int          errors = 0;

   lbr_ctrl #(.DATA_WIDTH(32), .LBR_SIZE(16)) dut (
      .clock(clock), .reset(reset), .lbr_enable(lbr_enable), .type_mask(type_mask),
      .br_valid(br_valid), .br_ready(br_ready), .br_from(br_from), .br_to(br_to),
      .br_type(br_type), .freeze_req(freeze_req), .freeze_clr(freeze_clr),
      .clr_req(clr_req), .frozen(frozen), .busy(busy), .tos(tos),
      .sw_rd_req(sw_rd_req), .sw_rd_sel(sw_rd_sel), .sw_rd_ready(sw_rd_ready),
      .sw_rd_valid(sw_rd_valid), .sw_rd_data(sw_rd_data),
      .rf_read_sel(rf_read_sel), .rf_read_data(rf_read_data),
      .rf_wEn0(rf_wEn0), .rf_wEn1(rf_wEn1), .rf_wEn2(rf_wEn2),
      .rf_write_sel0(rf_write_sel0), .rf_write_sel1(rf_write_sel1), .rf_write_sel2(rf_write_sel2),
      .rf_write_data0(rf_write_data0), .rf_write_data1(rf_write_data1), .rf_write_data2(rf_write_data2)
   );

   always #5 clock = ~clock;

   // register file: read-before-write, TOS entry resets to 15
   assign rf_read_data = mem[rf_read_sel];
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= (i == 32) ? 32'd15 : 32'd0;
      end else begin
         if (rf_wEn0) mem[rf_write_sel0] <= rf_write_data0;
         if (rf_wEn1) mem[rf_write_sel1] <= rf_write_data1;
         if (rf_wEn2) mem[rf_write_sel2] <= rf_write_data2;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic ev(input logic [31:0] f, input logic [31:0] t, input logic [1:0] ty);
      br_valid = 1'b1;
      br_from  = f;
      br_to    = t;
      br_type  = ty;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step;
      step;
      reset = 1'b0;
      #1;
      chk("rst_tos", tos, 15);
      chk("rst_busy", busy, 0);
      chk("rst_frozen", frozen, 0);
      chk("rst_br_ready", br_ready, 1);
      chk("rst_wen", {rf_wEn0, rf_wEn1, rf_wEn2}, 0);
      chk("rst_rd_valid", sw_rd_valid, 0);
      chk("rst_rd_data", sw_rd_data, 0);
      // three back-to-back events
      ev(32'h100, 32'h200, 2'd0);
      chk("e0_wen", {rf_wEn0, rf_wEn1, rf_wEn2}, 3'b111);
      chk("e0_sel", {rf_write_sel0, rf_write_sel1, rf_write_sel2}, {6'd0, 6'd16, 6'd32});
      chk("e0_data", {rf_write_data0, rf_write_data1}, {32'h100, 32'h200});
      chk("e0_tosdata", rf_write_data2, 0);
      step;
      chk("e0_tos", tos, 0);
      ev(32'h104, 32'h300, 2'd1);
      chk("e1_sel", {rf_write_sel0, rf_write_sel1, rf_write_sel2}, {6'd1, 6'd17, 6'd32});
      chk("e1_tosdata", rf_write_data2, 1);
      step;
      chk("e1_tos", tos, 1);
      ev(32'h108, 32'h400, 2'd2);
      chk("e2_sel", {rf_write_sel0, rf_write_sel1, rf_write_sel2}, {6'd2, 6'd18, 6'd32});
      chk("e2_data", {rf_write_data0, rf_write_data1, rf_write_data2}, {32'h108, 32'h400, 32'd2});
      step;
      chk("e2_tos", tos, 2);
      br_valid = 1'b0;
      sw_rd_req = 1'b1;
      sw_rd_sel = 6'd32;
      #1;
      chk("rd_sel_comb", rf_read_sel, 32);
      chk("rd_valid_pre", sw_rd_valid, 0);
      step;
      chk("rd_valid", sw_rd_valid, 1);
      chk("rd_tos_entry", sw_rd_data, 2);
      sw_rd_sel = 6'd17;
      step;
      chk("rd_to1", sw_rd_data, 32'h300);
      sw_rd_req = 1'b0;
      step;
      chk("rd_valid_drop", sw_rd_valid, 0);
      chk("rd_sel_hold", rf_read_sel, 17);
      // wrap: tos 2 -> 15 -> 0
      for (int i = 0; i < 14; i++) begin
         ev(32'h1000 + i, 32'h2000 + i, 2'(i));
         if (i == 13) chk("wrap_sel", {rf_write_sel0, rf_write_sel1}, {6'd0, 6'd16});
         step;
      end
      chk("wrap_tos", tos, 0);
      br_valid = 1'b0;
      sw_rd_req = 1'b1;
      sw_rd_sel = 6'd0;
      step;
      chk("wrap_from0", sw_rd_data, 32'h100D);
      sw_rd_sel = 6'd16;
      step;
      chk("wrap_to0", sw_rd_data, 32'h200D);
      sw_rd_req = 1'b0;
      // type filtering
      type_mask = 4'b0001;
      for (int t = 1; t < 4; t++) begin
         ev(32'h5000, 32'h6000, 2'(t));
         chk("mask_ready", br_ready, 1);
         chk("mask_drop", rf_wEn0, 0);
         step;
      end
      chk("mask_tos", tos, 0);
      ev(32'h500, 32'h580, 2'd0);
      chk("mask_rec", {rf_wEn0, rf_write_sel0}, {1'b1, 6'd1});
      step;
      chk("mask_tos2", tos, 1);
      type_mask = 4'hF;
      // freeze with same-cycle event
      ev(32'h600, 32'h680, 2'd0);
      freeze_req = 1'b1;
      #1;
      chk("frz_rec", {rf_wEn0, rf_write_sel0}, {1'b1, 6'd2});
      step;
      freeze_req = 1'b0;
      chk("frz_state", frozen, 1);
      chk("frz_tos", tos, 2);
      for (int i = 0; i < 2; i++) begin
         ev(32'h650, 32'h6A0, 2'd1);
         chk("frz_drop", {br_ready, rf_wEn0}, 2'b10);
         step;
      end
      br_valid = 1'b0;
      freeze_clr = 1'b1;
      step;
      freeze_clr = 1'b0;
      chk("unfrz", frozen, 0);
      ev(32'h700, 32'h780, 2'd3);
      chk("unfrz_rec", {rf_wEn0, rf_write_sel0}, {1'b1, 6'd3});
      step;
      ev(32'h800, 32'h880, 2'd0);
      step;
      ev(32'h900, 32'h980, 2'd0);
      step;
      br_valid = 1'b0;
      freeze_req = 1'b1;
      step;
      freeze_req = 1'b0;
      chk("pre_clr", {frozen, tos}, {1'b1, 4'd5});
      // clear from FROZEN; concurrent event dropped
      clr_req = 1'b1;
      ev(32'hBAD, 32'hBAD, 2'd0);
      chk("clr_drop", rf_wEn0, 0);
      step;
      clr_req = 1'b0;
      br_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("clr_busy", {busy, frozen, br_ready, sw_rd_ready}, 4'b1000);
         chk("clr_wr", {rf_wEn0, rf_wEn1, rf_write_sel0, rf_write_sel1}, {2'b11, 6'(k), 6'(16 + k)});
         chk("clr_data", {rf_write_data0, rf_write_data1}, 64'd0);
         chk("clr_wen2", rf_wEn2, k == 15);
         chk("clr_no_rd", sw_rd_valid, 0);
         if (k == 15) chk("clr_tosdata", {rf_write_sel2, rf_write_data2}, {6'd32, 32'd15});
         clr_req = (k == 3);
         sw_rd_req = (k == 5);
         step;
      end
      clr_req = 1'b0;
      sw_rd_req = 1'b0;
      chk("clr_done", {busy, frozen, br_ready, tos}, {3'b001, 4'd15});
      sw_rd_req = 1'b1;
      for (int i = 0; i < 32; i++) begin
         sw_rd_sel = 6'(i);
         step;
         chk("clr_entry", {sw_rd_valid, sw_rd_data}, {1'b1, 32'd0});
      end
      sw_rd_sel = 6'd32;
      step;
      chk("clr_tos_entry", sw_rd_data, 15);
      sw_rd_req = 1'b0;
      // reset in the middle of a clear
      clr_req = 1'b1;
      step;
      clr_req = 1'b0;
      repeat (7) step;
      chk("mid_clr", {busy, rf_write_sel0}, {1'b1, 6'd7});
      reset = 1'b1;
      step;
      reset = 1'b0;
      #1;
      chk("rst_mid_state", {busy, frozen, tos}, {2'b00, 4'd15});
      chk("rst_mid_wen", {rf_wEn0, rf_wEn1, rf_wEn2}, 0);
      chk("rst_mid_ready", br_ready, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
